xadac_spill: RTL and testbench

Timing-cut stage for the xadac accelerator interface. It sits directly upstream of the xadac request multiplexer, between the CVA6 core-side xadac port and the mux slave port. It inserts an optional full-throughput two-entry spill register on each of the four channels (dec_req, dec_rsp, exe_req, exe_rsp). This breaks every valid/ready/data combinational path between core and accelerators without costing bandwidth.

---
 rtl/xadac_spill_if.sv | 57 +++++
 rtl/xadac_spill.sv | 175 +++++++++++++++++
 tb/tb_xadac_spill.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadac_spill_if.sv
// Payload types and the valid/ready interface shared by the core-side and mux-side
// ports of the xadac accelerator path.
package xadac_pkg;

  localparam int unsigned IdW   = 4;
  localparam int unsigned WordW = 32;

  typedef struct packed {
    logic [WordW-1:0] instr;
    logic [IdW-1:0]   id;
  } dec_req_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic           accept;
  } dec_rsp_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [WordW-1:0] rs1;
    logic [WordW-1:0] rs2;
  } exe_req_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [WordW-1:0] rd;
  } exe_rsp_t;

endpackage

interface xadac_if;
  import xadac_pkg::*;

  logic     dec_req_valid;
  logic     dec_req_ready;
  dec_req_t dec_req;
  logic     dec_rsp_valid;
  logic     dec_rsp_ready;
  dec_rsp_t dec_rsp;
  logic     exe_req_valid;
  logic     exe_req_ready;
  exe_req_t exe_req;
  logic     exe_rsp_valid;
  logic     exe_rsp_ready;
  exe_rsp_t exe_rsp;

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
  );

endinterface

// File: rtl/xadac_spill.sv
// Timing-cut stage between the core-side xadac port and the request mux: one optional
// two-entry spill register per channel, full throughput, all handshake paths broken.

module xadac_spill_reg #(
  parameter int unsigned W   = 1,
  parameter bit          Cut = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic         o_empty
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [W-1:0] r_data_a;
  logic [W-1:0] r_data_b;
  logic         w_reg_in_ready;
  logic         w_reg_out_valid;
  logic         w_push;
  logic         w_pop;
  logic         w_load_a;
  logic         w_load_b;
  logic         w_a_from_b;

  // Handshake flags are decoded from registered state only.
  assign w_reg_in_ready  = (r_state != ST_TWO);
  assign w_reg_out_valid = (r_state != ST_EMPTY);
  assign w_push          = Cut & i_in_valid & w_reg_in_ready;
  assign w_pop           = Cut & w_reg_out_valid & i_out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_a_from_b  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt = ST_ONE;
          w_load_a    = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_push && w_pop) begin
          w_load_a = 1'b1;
        end else if (w_push) begin
          w_state_nxt = ST_TWO;
          w_load_b    = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt = ST_ONE;
          w_load_a    = 1'b1;
          w_a_from_b  = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      if (w_load_a) r_data_a <= w_a_from_b ? r_data_b : i_in_data;
      if (w_load_b) r_data_b <= i_in_data;
    end
  end

  // Without a cut the channel is a plain wire and never blocks idle.
  assign o_out_valid = Cut ? w_reg_out_valid : i_in_valid;
  assign o_out_data  = Cut ? r_data_a : i_in_data;
  assign o_in_ready  = Cut ? w_reg_in_ready : i_out_ready;
  assign o_empty     = Cut ? (r_state == ST_EMPTY) : 1'b1;

endmodule

module xadac_spill
  import xadac_pkg::*;
#(
  parameter bit CutDecReq = 1'b1,
  parameter bit CutDecRsp = 1'b1,
  parameter bit CutExeReq = 1'b1,
  parameter bit CutExeRsp = 1'b1
) (
  input  logic   clk,
  input  logic   rstn,
  xadac_if.slv   slv,
  xadac_if.mst   mst,
  output logic   idle
);

  localparam int unsigned DecReqW = $bits(dec_req_t);
  localparam int unsigned DecRspW = $bits(dec_rsp_t);
  localparam int unsigned ExeReqW = $bits(exe_req_t);
  localparam int unsigned ExeRspW = $bits(exe_rsp_t);

  logic w_empty_dec_req;
  logic w_empty_dec_rsp;
  logic w_empty_exe_req;
  logic w_empty_exe_rsp;

  xadac_spill_reg #(.W(DecReqW), .Cut(CutDecReq)) u_dec_req (
    .clk         (clk),
    .rstn        (rstn),
    .i_in_valid  (slv.dec_req_valid),
    .o_in_ready  (slv.dec_req_ready),
    .i_in_data   (slv.dec_req),
    .o_out_valid (mst.dec_req_valid),
    .i_out_ready (mst.dec_req_ready),
    .o_out_data  (mst.dec_req),
    .o_empty     (w_empty_dec_req)
  );

  xadac_spill_reg #(.W(DecRspW), .Cut(CutDecRsp)) u_dec_rsp (
    .clk         (clk),
    .rstn        (rstn),
    .i_in_valid  (mst.dec_rsp_valid),
    .o_in_ready  (mst.dec_rsp_ready),
    .i_in_data   (mst.dec_rsp),
    .o_out_valid (slv.dec_rsp_valid),
    .i_out_ready (slv.dec_rsp_ready),
    .o_out_data  (slv.dec_rsp),
    .o_empty     (w_empty_dec_rsp)
  );

  xadac_spill_reg #(.W(ExeReqW), .Cut(CutExeReq)) u_exe_req (
    .clk         (clk),
    .rstn        (rstn),
    .i_in_valid  (slv.exe_req_valid),
    .o_in_ready  (slv.exe_req_ready),
    .i_in_data   (slv.exe_req),
    .o_out_valid (mst.exe_req_valid),
    .i_out_ready (mst.exe_req_ready),
    .o_out_data  (mst.exe_req),
    .o_empty     (w_empty_exe_req)
  );

  xadac_spill_reg #(.W(ExeRspW), .Cut(CutExeRsp)) u_exe_rsp (
    .clk         (clk),
    .rstn        (rstn),
    .i_in_valid  (mst.exe_rsp_valid),
    .o_in_ready  (mst.exe_rsp_ready),
    .i_in_data   (mst.exe_rsp),
    .o_out_valid (slv.exe_rsp_valid),
    .i_out_ready (slv.exe_rsp_ready),
    .o_out_data  (slv.exe_rsp),
    .o_empty     (w_empty_exe_rsp)
  );

  assign idle = w_empty_dec_req & w_empty_dec_rsp & w_empty_exe_req & w_empty_exe_rsp;

endmodule

// File: tb/tb_xadac_spill.sv
// Directed and randomized checks of xadac_spill: all channels cut, plus a second
// instance with exe_req in bypass.
module tb_xadac_spill;
  import xadac_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Channel index: 0 dec_req, 1 dec_rsp, 2 exe_req, 3 exe_rsp
  logic [3:0]  in_vld  = '0;
  logic [67:0] in_dat [4];
  logic [3:0]  out_rdy = '0;
  logic [3:0]  in_rdy;
  logic [3:0]  out_vld;
  logic [67:0] out_dat [4];
  logic        idle;
  logic        idle2;

  logic     byp_vld = 1'b0;
  logic     byp_rdy = 1'b0;
  exe_req_t byp_dat = '0;

  logic [67:0] sb [4][$];

  xadac_if s_if ();
  xadac_if m_if ();
  xadac_if s2_if ();
  xadac_if m2_if ();

  xadac_spill u_dut (
    .clk  (clk),
    .rstn (rstn),
    .slv  (s_if),
    .mst  (m_if),
    .idle (idle)
  );

  xadac_spill #(.CutExeReq(1'b0)) u_dut_byp (
    .clk  (clk),
    .rstn (rstn),
    .slv  (s2_if),
    .mst  (m2_if),
    .idle (idle2)
  );

  assign s_if.dec_req_valid = in_vld[0];
  assign s_if.dec_req       = in_dat[0][35:0];
  assign in_rdy[0]          = s_if.dec_req_ready;
  assign out_vld[0]         = m_if.dec_req_valid;
  assign out_dat[0]         = {32'd0, m_if.dec_req};
  assign m_if.dec_req_ready = out_rdy[0];

  assign m_if.dec_rsp_valid = in_vld[1];
  assign m_if.dec_rsp       = in_dat[1][4:0];
  assign in_rdy[1]          = m_if.dec_rsp_ready;
  assign out_vld[1]         = s_if.dec_rsp_valid;
  assign out_dat[1]         = {63'd0, s_if.dec_rsp};
  assign s_if.dec_rsp_ready = out_rdy[1];

  assign s_if.exe_req_valid = in_vld[2];
  assign s_if.exe_req       = in_dat[2];
  assign in_rdy[2]          = s_if.exe_req_ready;
  assign out_vld[2]         = m_if.exe_req_valid;
  assign out_dat[2]         = m_if.exe_req;
  assign m_if.exe_req_ready = out_rdy[2];

  assign m_if.exe_rsp_valid = in_vld[3];
  assign m_if.exe_rsp       = in_dat[3][35:0];
  assign in_rdy[3]          = m_if.exe_rsp_ready;
  assign out_vld[3]         = s_if.exe_rsp_valid;
  assign out_dat[3]         = {32'd0, s_if.exe_rsp};
  assign s_if.exe_rsp_ready = out_rdy[3];

  assign s2_if.dec_req_valid = 1'b0;
  assign s2_if.dec_req       = '0;
  assign m2_if.dec_req_ready = 1'b1;
  assign m2_if.dec_rsp_valid = 1'b0;
  assign m2_if.dec_rsp       = '0;
  assign s2_if.dec_rsp_ready = 1'b1;
  assign s2_if.exe_req_valid = byp_vld;
  assign s2_if.exe_req       = byp_dat;
  assign m2_if.exe_req_ready = byp_rdy;
  assign m2_if.exe_rsp_valid = 1'b0;
  assign m2_if.exe_rsp       = '0;
  assign s2_if.exe_rsp_ready = 1'b1;

  // Output side must hold valid and payload while stalled.
  for (genvar c = 0; c < 4; c++) begin : g_chk
    a_stable: assert property (@(posedge clk) disable iff (!rstn)
      (out_vld[c] && !out_rdy[c]) |=> (out_vld[c] && $stable(out_dat[c])))
      else $error("FAIL out_stable ch%0d", c);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [67:0] ch_mask(int c);
    logic [67:0] m;
    int w;
    case (c)
      0:       w = 36;
      1:       w = 5;
      2:       w = 68;
      default: w = 36;
    endcase
    m = '1;
    m = m >> (68 - w);
    return m;
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 4; c++) in_dat[c] = '0;
    rstn = 1'b0;
    tick(); tick();
    checks++; if (out_vld !== 4'b0000) begin errors++; $display("FAIL rst_out_valid got=%b exp=0000", out_vld); end
    checks++; if (in_rdy !== 4'b1111) begin errors++; $display("FAIL rst_in_ready got=%b exp=1111", in_rdy); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got=%b exp=1", idle); end
    checks++; if (out_dat[2] !== 68'd0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_dat[2]); end
    rstn = 1'b1;
    #1;
    checks++; if (out_vld !== 4'b0000) begin errors++; $display("FAIL rel_out_valid got=%b exp=0000", out_vld); end
    checks++; if (in_rdy !== 4'b1111) begin errors++; $display("FAIL rel_in_ready got=%b exp=1111", in_rdy); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rel_idle got=%b exp=1", idle); end
    tick();
  endtask

  task automatic test_single();
    logic [67:0] exp_d;
    exp_d = {32'd0, 32'h0000_000B, 4'd3};
    out_rdy[0] = 1'b1;
    in_vld[0]  = 1'b1;
    in_dat[0]  = exp_d;
    checks++; if (out_vld[0] !== 1'b0) begin errors++; $display("FAIL single_c0_valid got=%b exp=0", out_vld[0]); end
    tick();
    in_vld[0] = 1'b0;
    checks++; if (out_vld[0] !== 1'b1) begin errors++; $display("FAIL single_c1_valid got=%b exp=1", out_vld[0]); end
    checks++; if (out_dat[0] !== exp_d) begin errors++; $display("FAIL single_c1_data got=%h exp=%h", out_dat[0], exp_d); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_c1_idle got=%b exp=0", idle); end
    tick();
    checks++; if (out_vld[0] !== 1'b0) begin errors++; $display("FAIL single_c2_valid got=%b exp=0", out_vld[0]); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_c2_idle got=%b exp=1", idle); end
  endtask

  task automatic test_back_to_back();
    logic [67:0] exp_d;
    out_rdy[2] = 1'b1;
    for (int cyc = 0; cyc <= 16; cyc++) begin
      if (cyc < 16) begin
        in_vld[2] = 1'b1;
        in_dat[2] = {4'(cyc), 32'hA000_0000 + 32'(cyc), 32'h5000_0000 + 32'(cyc)};
        checks++; if (in_rdy[2] !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", cyc, in_rdy[2]); end
      end else begin
        in_vld[2] = 1'b0;
      end
      if (cyc >= 1) begin
        exp_d = {4'(cyc - 1), 32'hA000_0000 + 32'(cyc - 1), 32'h5000_0000 + 32'(cyc - 1)};
        checks++; if (out_vld[2] !== 1'b1) begin errors++; $display("FAIL b2b_valid cyc=%0d got=%b exp=1", cyc, out_vld[2]); end
        checks++; if (out_dat[2] !== exp_d) begin errors++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", cyc, out_dat[2], exp_d); end
      end
      tick();
    end
    checks++; if (out_vld[2] !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%b exp=0", out_vld[2]); end
  endtask

  task automatic test_backpressure();
    out_rdy[1] = 1'b0;
    in_vld[1]  = 1'b1;
    in_dat[1]  = {63'd0, 4'd5, 1'b1};
    checks++; if (in_rdy[1] !== 1'b1) begin errors++; $display("FAIL bp_c0_ready got=%b exp=1", in_rdy[1]); end
    tick();
    in_dat[1] = {63'd0, 4'd6, 1'b1};
    checks++; if (in_rdy[1] !== 1'b1) begin errors++; $display("FAIL bp_c1_ready got=%b exp=1", in_rdy[1]); end
    tick();
    in_dat[1] = {63'd0, 4'd7, 1'b1};
    checks++; if (in_rdy[1] !== 1'b0) begin errors++; $display("FAIL bp_c2_ready got=%b exp=0", in_rdy[1]); end
    checks++; if (out_dat[1] !== {63'd0, 4'd5, 1'b1}) begin errors++; $display("FAIL bp_c2_data got=%h exp=b", out_dat[1]); end
    tick();
    checks++; if (in_rdy[1] !== 1'b0) begin errors++; $display("FAIL bp_c3_ready got=%b exp=0", in_rdy[1]); end
    checks++; if (out_dat[1] !== {63'd0, 4'd5, 1'b1}) begin errors++; $display("FAIL bp_c3_data got=%h exp=b", out_dat[1]); end
    out_rdy[1] = 1'b1;
    tick();
    checks++; if (in_rdy[1] !== 1'b1) begin errors++; $display("FAIL bp_c4_ready got=%b exp=1", in_rdy[1]); end
    checks++; if (out_dat[1] !== {63'd0, 4'd6, 1'b1}) begin errors++; $display("FAIL bp_c4_data got=%h exp=d", out_dat[1]); end
    tick();
    in_vld[1] = 1'b0;
    checks++; if (out_vld[1] !== 1'b1) begin errors++; $display("FAIL bp_c5_valid got=%b exp=1", out_vld[1]); end
    checks++; if (out_dat[1] !== {63'd0, 4'd7, 1'b1}) begin errors++; $display("FAIL bp_c5_data got=%h exp=f", out_dat[1]); end
    tick();
    checks++; if (out_vld[1] !== 1'b0) begin errors++; $display("FAIL bp_c6_valid got=%b exp=0", out_vld[1]); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL bp_c6_idle got=%b exp=1", idle); end
  endtask

  task automatic run_random(int n, bit drain);
    logic [3:0]  acc;
    logic [95:0] r;
    logic [67:0] exp_d;
    acc = '0;
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (acc[c]) in_vld[c] = 1'b0;
        if (!in_vld[c] && !drain && ($urandom_range(0, 9) < 6)) begin
          r = {$urandom(), $urandom(), $urandom()};
          in_vld[c] = 1'b1;
          in_dat[c] = r[67:0] & ch_mask(c);
        end
        out_rdy[c] = drain ? 1'b1 : ($urandom_range(0, 9) < 6);
      end
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        acc[c] = in_vld[c] & in_rdy[c];
        if (acc[c]) sb[c].push_back(in_dat[c]);
        if (out_vld[c] && out_rdy[c]) begin
          checks++;
          if (sb[c].size() == 0) begin
            errors++;
            $display("FAIL rand_extra ch%0d got=%h exp=none", c, out_dat[c]);
          end else begin
            exp_d = sb[c].pop_front();
            if (out_dat[c] !== exp_d) begin
              errors++;
              $display("FAIL rand_data ch%0d got=%h exp=%h", c, out_dat[c], exp_d);
            end
          end
        end
      end
      tick();
    end
    for (int c = 0; c < 4; c++) if (acc[c]) in_vld[c] = 1'b0;
  endtask

  task automatic test_random();
    in_vld = '0;
    run_random(10000, 1'b0);
    run_random(20, 1'b1);
    in_vld = '0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (sb[c].size() != 0) begin errors++; $display("FAIL rand_lost ch%0d got=%0d exp=0 pending", c, sb[c].size()); end
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rand_idle got=%b exp=1", idle); end
  endtask

  task automatic test_reset_mid();
    logic [67:0] d3;
    d3 = {32'd0, 4'd9, 32'hCAFE_0009};
    out_rdy = '0;
    in_vld[3] = 1'b1;
    in_dat[3] = {32'd0, 4'd1, 32'h1111_0001};
    tick();
    in_dat[3] = {32'd0, 4'd2, 32'h2222_0002};
    tick();
    in_vld[3] = 1'b0;
    checks++; if (in_rdy[3] !== 1'b0) begin errors++; $display("FAIL mid_full_ready got=%b exp=0", in_rdy[3]); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL mid_full_idle got=%b exp=0", idle); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (out_vld[3] !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", out_vld[3]); end
    checks++; if (in_rdy[3] !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", in_rdy[3]); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_rst_idle got=%b exp=1", idle); end
    checks++; if (out_dat[3] !== 68'd0) begin errors++; $display("FAIL mid_rst_data got=%h exp=0", out_dat[3]); end
    tick();
    rstn = 1'b1;
    out_rdy[3] = 1'b1;
    in_vld[3]  = 1'b1;
    in_dat[3]  = d3;
    tick();
    in_vld[3] = 1'b0;
    checks++; if (out_vld[3] !== 1'b1) begin errors++; $display("FAIL post_rst_valid got=%b exp=1", out_vld[3]); end
    checks++; if (out_dat[3] !== d3) begin errors++; $display("FAIL post_rst_data got=%h exp=%h", out_dat[3], d3); end
    tick();
    checks++; if (out_vld[3] !== 1'b0) begin errors++; $display("FAIL post_rst_drain got=%b exp=0", out_vld[3]); end
  endtask

  task automatic test_bypass();
    exe_req_t d;
    d = '{id: 4'd12, rs1: 32'hDEAD_BEEF, rs2: 32'h0123_4567};
    byp_dat = d;
    byp_vld = 1'b1;
    byp_rdy = 1'b0;
    #1;
    checks++; if (m2_if.exe_req_valid !== 1'b1) begin errors++; $display("FAIL byp_valid got=%b exp=1", m2_if.exe_req_valid); end
    checks++; if (m2_if.exe_req !== d) begin errors++; $display("FAIL byp_data got=%h exp=%h", m2_if.exe_req, d); end
    checks++; if (s2_if.exe_req_ready !== 1'b0) begin errors++; $display("FAIL byp_ready_lo got=%b exp=0", s2_if.exe_req_ready); end
    byp_rdy = 1'b1;
    #1;
    checks++; if (s2_if.exe_req_ready !== 1'b1) begin errors++; $display("FAIL byp_ready_hi got=%b exp=1", s2_if.exe_req_ready); end
    tick();
    checks++; if (idle2 !== 1'b1) begin errors++; $display("FAIL byp_idle got=%b exp=1", idle2); end
    byp_vld = 1'b0;
    #1;
    checks++; if (m2_if.exe_req_valid !== 1'b0) begin errors++; $display("FAIL byp_valid_lo got=%b exp=0", m2_if.exe_req_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
